// File: rtl/cpu_types_pkg.sv
// Shared types for the core's memory-side blocks: RAM status, arbiter states
// and the width of the instruction-fetch starvation streak counter.
// Imported by mem_arbiter and arb_streak_counter.
package cpu_types_pkg;

    // Status reported by the RAM model every cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISERVE = 2'd1,
        DSERVE = 2'd2
    } arb_state_t;

    // Width of the data-completion streak counter (holds 0..7).
    localparam int DSTREAK_W = 3;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating streak counter: counts consecutive data completions while an
// instruction fetch is pending, flags when the limit is reached.
// Ports: clk_i/rst_i (sync active-high), clr_i (priority clear), inc_i, at_max_o.
module arb_streak_counter
    import cpu_types_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam logic [DSTREAK_W-1:0] MAX_C = DSTREAK_W'(MAX);

    logic [DSTREAK_W-1:0] cnt_q;
    logic [DSTREAK_W-1:0] cnt_d;

    // Clear beats increment; increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access; data has
// priority, each granted access is held until the RAM reports ACCESS.
// Ports: CLK/RST (sync active-high), i*/d* requester sides, ram* RAM side.
// Optional MEM_ARB_FAIRNESS_EN: after DSTREAK_MAX data completions with a
// fetch pending, the fetch is forced through at the next IDLE.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    // instruction side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    // data side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic d_req;
    logic i_done;
    logic d_done;
    logic fetch_force;

    assign d_req = dREN | dWEN;

    // A completion needs the requester still asserting; a dropped request is
    // an abort, never a completion.
    assign i_done = (state_q == ISERVE) && iREN  && (ramstate == ACCESS);
    assign d_done = (state_q == DSERVE) && d_req && (ramstate == ACCESS);

    assign iwait = iREN  & ~((state_q == ISERVE) && (ramstate == ACCESS));
    assign dwait = d_req & ~((state_q == DSERVE) && (ramstate == ACCESS));

    assign iload = ramload;
    assign dload = ramload;

`ifdef MEM_ARB_FAIRNESS_EN
    logic streak_at_max;

    // Counts data wins only while a fetch is actually waiting behind them.
    arb_streak_counter #(
        .MAX(DSTREAK_MAX)
    ) u_streak (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (i_done | ~iREN),
        .inc_i   (d_done & iREN),
        .at_max_o(streak_at_max)
    );

    assign fetch_force = streak_at_max;
`else
    // Strict data priority; for any legal DSTREAK_MAX this is constant 0.
    assign fetch_force = (DSTREAK_MAX < 1);
`endif

    always_comb begin
        state_d  = state_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IDLE: begin
                if (d_req && !(iREN && fetch_force)) begin
                    state_d = DSERVE;
                end else if (iREN) begin
                    state_d = ISERVE;
                end
            end
            ISERVE: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramstate == ACCESS) begin
                        state_d = IDLE;
                    end
                end
            end
            DSERVE: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    // A simultaneous read+write is treated as a write.
                    if (dWEN) begin
                        ramWEN = 1'b1;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ramstate == ACCESS) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    int n_checks = 0;
    int n_fails  = 0;

    logic [131:0] exp_q[$];
    string        nm_q[$];

    mem_arbiter #(.DSTREAK_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [131:0] e;
            logic [131:0] a;
            string nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            a  = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload};
            n_checks++;
            if (a !== e) begin
                n_fails++;
                $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h iw=%b dw=%b il=%h dl=%h, want ren=%b wen=%b addr=%h store=%h iw=%b dw=%b il=%h dl=%h",
                         nm, a[131], a[130], a[129:98], a[97:66], a[65], a[64], a[63:32], a[31:0],
                         e[131], e[130], e[129:98], e[97:66], e[65], e[64], e[63:32], e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rst, input logic ir, input logic dr, input logic dw,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                         input logic [31:0] ld, input ramstate_t rs);
        RST = rst; iREN = ir; dREN = dr; dWEN = dw;
        iaddr = ia; daddr = da; dstore = ds; ramload = ld; ramstate = rs;
    endtask

    // Read data is a passthrough of ramload on both sides.
    task automatic push_exp(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] store, input logic iw, input logic dw,
                            input string nm);
        exp_q.push_back({ren, wen, addr, store, iw, dw, ramload, ramload});
        nm_q.push_back(nm);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, FREE);
        tick();
        // Reset: outputs idle, waits follow requests.
        drive(1, 1, 0, 1, 32'h10, 32'h20, 32'h30, 32'h0, ACCESS);
        push_exp(0, 0, 0, 0, 1, 1, "reset_idle");

        // Single fetch.
        tick(); drive(0, 1, 0, 0, 32'h0, 0, 0, 32'h8C010004, ACCESS);
        push_exp(0, 0, 0, 0, 1, 0, "fetch_c0_idle");
        tick(); push_exp(1, 0, 32'h0, 0, 0, 0, "fetch_c1_serve");
        tick(); drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h8C010004, ACCESS);
        push_exp(0, 0, 0, 0, 0, 0, "fetch_c2_idle");

        // Priority: data first, then fetch.
        tick(); drive(0, 1, 1, 0, 32'h4, 32'h100, 32'h12345678, 32'h11111111, ACCESS);
        push_exp(0, 0, 0, 0, 1, 1, "prio_idle");
        tick(); push_exp(1, 0, 32'h100, 32'h12345678, 1, 0, "prio_dserve");
        tick(); dREN = 0;
        push_exp(0, 0, 0, 0, 1, 0, "prio_idle2");
        tick(); push_exp(1, 0, 32'h4, 0, 0, 0, "prio_iserve");
        tick(); iREN = 0;
        push_exp(0, 0, 0, 0, 0, 0, "prio_idle3");

        // Wait states on a write (read also asserted: write wins).
        tick(); drive(0, 0, 1, 1, 0, 32'h200, 32'hDEADBEEF, 32'h0, BUSY);
        push_exp(0, 0, 0, 0, 0, 1, "wr_idle");
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) ramstate = ACCESS;
            push_exp(0, 1, 32'h200, 32'hDEADBEEF, 0, (k != 3), $sformatf("wr_serve%0d", k));
        end
        tick(); dREN = 0; dWEN = 0;
        push_exp(0, 0, 0, 0, 0, 0, "wr_idle2");

        // Abort: fetch drops in its second serve cycle.
        tick(); drive(0, 1, 0, 0, 32'h40, 0, 0, 32'h77, BUSY);
        push_exp(0, 0, 0, 0, 1, 0, "abort_idle");
        tick(); push_exp(1, 0, 32'h40, 0, 1, 0, "abort_serve1");
        tick(); iREN = 0;
        push_exp(0, 0, 32'h40, 0, 0, 0, "abort_serve2");
        tick(); push_exp(0, 0, 0, 0, 0, 0, "abort_idle2");
        // Arbiter is back in IDLE: a new data request is sampled here.
        tick(); drive(0, 0, 1, 0, 0, 32'h300, 0, 32'h99, ACCESS);
        push_exp(0, 0, 0, 0, 0, 1, "abort_newreq_idle");
        tick(); push_exp(1, 0, 32'h300, 0, 0, 0, "abort_newreq_serve");
        tick(); dREN = 0;
        push_exp(0, 0, 0, 0, 0, 0, "abort_idle3");

        // Build a data streak of 2 with a fetch pending, then reset mid-service.
        for (int k = 0; k < 2; k++) begin
            tick(); drive(0, 1, 1, 0, 32'h80, 32'h400, 32'h5, 32'hA, ACCESS);
            push_exp(0, 0, 0, 0, 1, 1, $sformatf("pre_idle%0d", k));
            tick(); push_exp(1, 0, 32'h400, 32'h5, 1, 0, $sformatf("pre_dserve%0d", k));
        end
        tick(); ramstate = BUSY;
        push_exp(0, 0, 0, 0, 1, 1, "rst_mid_idle");
        tick(); RST = 1;
        push_exp(1, 0, 32'h400, 32'h5, 1, 1, "rst_mid_dserve");
        tick(); RST = 0; ramstate = ACCESS;
        push_exp(0, 0, 0, 0, 1, 1, "rst_after_idle");

        // Fairness: both held high, ACCESS on every serve cycle. The streak
        // must have restarted from 0 at reset.
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                tick();
                push_exp(0, 0, 0, 0, 1, 1, $sformatf("fair_idle%0d", k));
            end
            tick();
`ifdef MEM_ARB_FAIRNESS_EN
            if (k == 4)
                push_exp(1, 0, 32'h80, 0, 0, 1, $sformatf("fair_serve%0d", k));
            else
                push_exp(1, 0, 32'h400, 32'h5, 1, 0, $sformatf("fair_serve%0d", k));
`else
            push_exp(1, 0, 32'h400, 32'h5, 1, 0, $sformatf("fair_serve%0d", k));
`endif
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, FREE);
        push_exp(0, 0, 0, 0, 0, 0, "final_idle");

        tick();
        @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d records left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
